px_skip_cfg_gen: RTL and testbench

//  Master end of px_skip_if: turns input/target frame sizes into the six skip fields consumed by px_skipper.
//  Per axis: to_skip = in - out; interval = in / to_skip; add_interval = in % to_skip.

---
 rtl/px_skip_cfg_pkg.sv | 29 ++
 rtl/px_skip_if.sv | 10 +
 rtl/px_skip_div.sv | 71 +++++++
 rtl/px_skip_cfg_gen.sv | 142 ++++++++++++++
 tb/tb_px_skip_cfg_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/px_skip_cfg_pkg.sv
// Shared types for the skip-field generator: field width, FSM states and the
// six-field bundle used for both the shadow and the live register sets.
package px_skip_cfg_pkg;

    localparam int SKIP_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC_PX  = 2'd1,
        CALC_LN  = 2'd2,
        WAIT_SOF = 2'd3
    } state_t;

    typedef struct packed {
        logic [SKIP_W-1:0] px_to_skip;
        logic [SKIP_W-1:0] px_interval;
        logic [SKIP_W-1:0] px_add;
        logic [SKIP_W-1:0] ln_to_skip;
        logic [SKIP_W-1:0] ln_interval;
        logic [SKIP_W-1:0] ln_add;
    } skip_fields_t;

    // A target larger than the source cannot be reached by skipping, so it degrades to pass-through.
    function automatic logic [SKIP_W-1:0] clamp_skip(input logic [SKIP_W-1:0] in_sz,
                                                     input logic [SKIP_W-1:0] out_sz);
        return (out_sz > in_sz) ? '0 : in_sz - out_sz;
    endfunction

endpackage

// File: rtl/px_skip_if.sv
// Skip-field bus between px_skip_cfg_gen (master) and px_skipper (slave).
interface px_skip_if;
    import px_skip_cfg_pkg::*;

    skip_fields_t fields;

    modport master (output fields);
    modport slave  (input  fields);

endinterface

// File: rtl/px_skip_div.sv
// 16-bit restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so done_o pulses 16 cycles after start_i.
module px_skip_div
    import px_skip_cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [SKIP_W-1:0] dividend_i,
    input  logic [SKIP_W-1:0] divisor_i,
    output logic [SKIP_W-1:0] quot_o,
    output logic [SKIP_W-1:0] rem_o,
    output logic              done_o
);

    logic [SKIP_W-1:0] quot_q, rem_q, divisor_q;
    logic [3:0]        cnt_q;
    logic              busy_q, done_q;

    logic [SKIP_W-1:0] src_rem, src_quot, src_div, rem_nxt, quot_nxt;
    logic [SKIP_W:0]   shifted, diff;

    always_comb begin
        src_rem  = start_i ? '0 : rem_q;
        src_quot = start_i ? dividend_i : quot_q;
        src_div  = start_i ? divisor_i : divisor_q;
        shifted  = {src_rem, src_quot[SKIP_W-1]};
        diff     = shifted - {1'b0, src_div};
        // Borrow out of the trial subtraction means the partial remainder is restored.
        if (diff[SKIP_W]) begin
            rem_nxt  = shifted[SKIP_W-1:0];
            quot_nxt = {src_quot[SKIP_W-2:0], 1'b0};
        end else begin
            rem_nxt  = diff[SKIP_W-1:0];
            quot_nxt = {src_quot[SKIP_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quot_q    <= quot_nxt;
                rem_q     <= rem_nxt;
                divisor_q <= divisor_i;
                cnt_q     <= 4'd15;
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                quot_q <= quot_nxt;
                rem_q  <= rem_nxt;
                cnt_q  <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign done_o = done_q;

endmodule

// File: rtl/px_skip_cfg_gen.sv
// Converts in/out frame sizes into px_skipper skip fields and applies them atomically.
// Optional PX_SKIP_CFG_CHECK_EN rejects out>in or out==0 requests with a cfg_err_o pulse.
module px_skip_cfg_gen
    import px_skip_cfg_pkg::*;
#(
    parameter bit SOF_SYNC = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [SKIP_W-1:0] in_width_i,
    input  logic [SKIP_W-1:0] in_height_i,
    input  logic [SKIP_W-1:0] out_width_i,
    input  logic [SKIP_W-1:0] out_height_i,
    input  logic              sof_i,
    output logic              busy_o,
`ifdef PX_SKIP_CFG_CHECK_EN
    output logic              cfg_err_o,
`endif
    output state_t            dbg_state_o,
    px_skip_if.master         skip_if
);

    // Handshake: a request transfers on the edge where cfg_valid_i and cfg_ready_o
    // are both high; the requester holds valid and the sizes until then.
    state_t            state_q;
    skip_fields_t      shadow_q, live_q;
    logic [SKIP_W-1:0] in_w_q, in_h_q, px_skip_q, ln_skip_q;
    logic              busy_q, div_run_q, apply_pend_q;
    logic              accept, cfg_bad, div_start, div_done;
    logic [SKIP_W-1:0] cur_skip, div_quot, div_rem;

    assign cfg_ready_o = (state_q == IDLE) && !apply_pend_q;
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign cur_skip    = (state_q == CALC_LN) ? ln_skip_q : px_skip_q;
    assign div_start   = (state_q == CALC_PX || state_q == CALC_LN) && !div_run_q && (cur_skip != '0);

`ifdef PX_SKIP_CFG_CHECK_EN
    logic err_q;

    assign cfg_bad = (out_width_i > in_width_i) || (out_height_i > in_height_i) ||
                     (out_width_i == '0) || (out_height_i == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) err_q <= 1'b0;
        else        err_q <= accept && cfg_bad;
    end

    assign cfg_err_o = err_q;
`else
    assign cfg_bad = 1'b0;
`endif

    px_skip_div u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .dividend_i ((state_q == CALC_LN) ? in_h_q : in_w_q),
        .divisor_i  (cur_skip),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .done_o     (div_done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            live_q       <= '0;
            in_w_q       <= '0;
            in_h_q       <= '0;
            px_skip_q    <= '0;
            ln_skip_q    <= '0;
            busy_q       <= 1'b0;
            div_run_q    <= 1'b0;
            apply_pend_q <= 1'b0;
        end else begin
            apply_pend_q <= 1'b0;
            if (apply_pend_q) begin
                live_q <= shadow_q;
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept && !cfg_bad) begin
                        in_w_q              <= in_width_i;
                        in_h_q              <= in_height_i;
                        px_skip_q           <= clamp_skip(in_width_i, out_width_i);
                        ln_skip_q           <= clamp_skip(in_height_i, out_height_i);
                        shadow_q.px_to_skip <= clamp_skip(in_width_i, out_width_i);
                        shadow_q.ln_to_skip <= clamp_skip(in_height_i, out_height_i);
                        busy_q              <= 1'b1;
                        state_q             <= CALC_PX;
                    end
                end
                CALC_PX: begin
                    if (px_skip_q == '0) begin
                        shadow_q.px_interval <= '0;
                        shadow_q.px_add      <= '0;
                        state_q              <= CALC_LN;
                    end else if (!div_run_q) begin
                        div_run_q <= 1'b1;
                    end else if (div_done) begin
                        shadow_q.px_interval <= div_quot;
                        shadow_q.px_add      <= div_rem;
                        div_run_q            <= 1'b0;
                        state_q              <= CALC_LN;
                    end
                end
                CALC_LN: begin
                    if (ln_skip_q == '0 || (div_run_q && div_done)) begin
                        shadow_q.ln_interval <= (ln_skip_q == '0) ? '0 : div_quot;
                        shadow_q.ln_add      <= (ln_skip_q == '0) ? '0 : div_rem;
                        div_run_q            <= 1'b0;
                        if (SOF_SYNC) begin
                            state_q <= WAIT_SOF;
                        end else begin
                            state_q      <= IDLE;
                            apply_pend_q <= 1'b1;
                        end
                    end else if (!div_run_q) begin
                        div_run_q <= 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (sof_i) begin
                        live_q  <= shadow_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign dbg_state_o    = state_q;
    assign skip_if.fields = live_q;

endmodule

// File: tb/tb_px_skip_cfg_gen.sv
// Directed bench for px_skip_cfg_gen: latency, atomic apply on sof, clamping and async reset.
module tb_px_skip_cfg_gen;
    import px_skip_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] in_w = '0, in_h = '0, out_w = '0, out_h = '0;
    logic        sof = 1'b0;
    logic        busy;
`ifdef PX_SKIP_CFG_CHECK_EN
    logic        cfg_err;
`endif
    state_t      dbg_state;
    int          checks = 0;
    int          errors = 0;

    px_skip_if skip_bus ();

    px_skip_cfg_gen #(.SOF_SYNC(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .in_width_i   (in_w),
        .in_height_i  (in_h),
        .out_width_i  (out_w),
        .out_height_i (out_h),
        .sof_i        (sof),
        .busy_o       (busy),
`ifdef PX_SKIP_CFG_CHECK_EN
        .cfg_err_o    (cfg_err),
`endif
        .dbg_state_o  (dbg_state),
        .skip_if      (skip_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t s, input int budget, output int n);
        n = 0;
        while (dbg_state !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic send_cfg(input logic [15:0] iw, ih, ow, oh);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        cfg_valid = 1'b1;
        in_w = iw; in_h = ih; out_w = ow; out_h = oh;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (skip_bus.fields !== '0) begin
            errors++; $display("FAIL reset_fields got %h want 0", skip_bus.fields);
        end
        checks++;
        if ({cfg_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL reset_ready_busy got %b want 10", {cfg_ready, busy});
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_downscale_1280();
        int n;
        skip_fields_t exp = '{16'd640, 16'd3, 16'd0, 16'd360, 16'd3, 16'd0};
        send_cfg(16'd1920, 16'd1080, 16'd1280, 16'd720);
        checks++;
        if ({busy, cfg_ready} !== 2'b10) begin
            errors++; $display("FAIL ds_busy_after_accept got %b want 10", {busy, cfg_ready});
        end
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 34) begin errors++; $display("FAIL ds_latency got %0d want 34", n); end
        repeat (3) tick();
        checks++;
        if (skip_bus.fields !== '0 || dbg_state !== WAIT_SOF) begin
            errors++; $display("FAIL ds_hold_before_sof got %h st %0d want 0 st 3", skip_bus.fields, dbg_state);
        end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL ds_fields got %h want %h", skip_bus.fields, exp);
        end
        checks++;
        if ({busy, cfg_ready} !== 2'b01 || dbg_state !== IDLE) begin
            errors++; $display("FAIL ds_after_apply got %b st %0d want 01 st 0", {busy, cfg_ready}, dbg_state);
        end
    endtask

    task automatic test_width_only();
        int n;
        skip_fields_t prev = skip_bus.fields;
        skip_fields_t exp = '{16'd920, 16'd2, 16'd80, 16'd0, 16'd0, 16'd0};
        send_cfg(16'd1920, 16'd1080, 16'd1000, 16'd1080);
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 18) begin errors++; $display("FAIL wo_latency got %0d want 18", n); end
        checks++;
        if (skip_bus.fields !== prev) begin
            errors++; $display("FAIL wo_no_early_update got %h want %h", skip_bus.fields, prev);
        end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL wo_fields got %h want %h", skip_bus.fields, exp);
        end
    endtask

    task automatic test_same_size();
        int n;
        send_cfg(16'd1920, 16'd1080, 16'd1920, 16'd1080);
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL same_latency got %0d want 2", n); end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== '0) begin
            errors++; $display("FAIL same_fields got %h want 0", skip_bus.fields);
        end
    endtask

    task automatic test_sof_in_calc();
        int n;
        skip_fields_t exp = '{16'd640, 16'd3, 16'd0, 16'd360, 16'd3, 16'd0};
        send_cfg(16'd1920, 16'd1080, 16'd1280, 16'd720);
        repeat (2) tick();
        sof = 1'b1;
        cfg_valid = 1'b1;
        in_w = 16'd100; in_h = 16'd100; out_w = 16'd50; out_h = 16'd50;
        tick();
        sof = 1'b0;
        checks++;
        if (dbg_state !== CALC_PX || skip_bus.fields !== '0 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL sof_calc_ignored got st %0d f %h rdy %b want st 1 f 0 rdy 0",
                               dbg_state, skip_bus.fields, cfg_ready);
        end
        repeat (3) tick();
        cfg_valid = 1'b0;
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 28) begin errors++; $display("FAIL sof_calc_latency got %0d want 28", n); end
        tick();
        checks++;
        if (skip_bus.fields !== '0) begin
            errors++; $display("FAIL sof_calc_hold got %h want 0", skip_bus.fields);
        end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL sof_calc_fields got %h want %h", skip_bus.fields, exp);
        end
    endtask

    task automatic test_reset_mid_calc();
        int n;
        send_cfg(16'd1920, 16'd1080, 16'd1000, 16'd540);
        wait_state(CALC_LN, 100, n);
        checks++;
        if (n != 17) begin errors++; $display("FAIL rst_mid_px_latency got %0d want 17", n); end
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (skip_bus.fields !== '0 || {cfg_ready, busy} !== 2'b10 || dbg_state !== IDLE) begin
            errors++; $display("FAIL rst_mid_async got f %h rb %b st %0d want f 0 rb 10 st 0",
                               skip_bus.fields, {cfg_ready, busy}, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (cfg_ready !== 1'b1 || dbg_state !== IDLE || skip_bus.fields !== '0) begin
            errors++; $display("FAIL rst_mid_release got rdy %b st %0d f %h want rdy 1 st 0 f 0",
                               cfg_ready, dbg_state, skip_bus.fields);
        end
    endtask

    task automatic test_out_gt_in();
`ifdef PX_SKIP_CFG_CHECK_EN
        send_cfg(16'd1920, 16'd1080, 16'd2000, 16'd720);
        checks++;
        if (cfg_err !== 1'b1 || dbg_state !== IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL err_pulse got err %b st %0d busy %b want 1 0 0", cfg_err, dbg_state, busy);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0 || skip_bus.fields !== '0) begin
            errors++; $display("FAIL err_single_cycle got err %b f %h want 0 f 0", cfg_err, skip_bus.fields);
        end
`else
        int n;
        skip_fields_t exp = '{16'd0, 16'd0, 16'd0, 16'd360, 16'd3, 16'd0};
        send_cfg(16'd1920, 16'd1080, 16'd2000, 16'd720);
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 18) begin errors++; $display("FAIL clamp_latency got %0d want 18", n); end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL clamp_fields got %h want %h", skip_bus.fields, exp);
        end
`endif
    endtask

    task automatic test_out_zero();
`ifdef PX_SKIP_CFG_CHECK_EN
        skip_fields_t prev = skip_bus.fields;
        send_cfg(16'd100, 16'd50, 16'd0, 16'd0);
        checks++;
        if (cfg_err !== 1'b1 || dbg_state !== IDLE) begin
            errors++; $display("FAIL zero_err got err %b st %0d want 1 0", cfg_err, dbg_state);
        end
        tick();
        checks++;
        if (skip_bus.fields !== prev) begin
            errors++; $display("FAIL zero_unchanged got %h want %h", skip_bus.fields, prev);
        end
`else
        int n;
        skip_fields_t exp = '{16'd100, 16'd1, 16'd0, 16'd50, 16'd1, 16'd0};
        send_cfg(16'd100, 16'd50, 16'd0, 16'd0);
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 34) begin errors++; $display("FAIL drop_latency got %0d want 34", n); end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL drop_fields got %h want %h", skip_bus.fields, exp);
        end
`endif
    endtask

    task automatic test_remainder();
        int n;
        skip_fields_t exp = '{16'd3, 16'd333, 16'd1, 16'd5, 16'd1, 16'd2};
        send_cfg(16'd1000, 16'd7, 16'd997, 16'd2);
        wait_state(WAIT_SOF, 100, n);
        checks++;
        if (n != 34) begin errors++; $display("FAIL rem_latency got %0d want 34", n); end
        pulse_sof();
        checks++;
        if (skip_bus.fields !== exp) begin
            errors++; $display("FAIL rem_fields got %h want %h", skip_bus.fields, exp);
        end
    endtask

    initial begin
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_downscale_1280();
        test_width_only();
        test_same_size();
        test_sof_in_calc();
        test_reset_mid_calc();
        test_out_gt_in();
        test_out_zero();
        test_remainder();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
